// File: rtl/credit_tx_if.sv
// Stream and link signals of the credit transmitter.
// master: credit_tx side; slave: upstream writer plus remote receiver.
interface credit_tx_if #(
   parameter int  DATA_WIDTH = 1,
   parameter type TYPE       = logic [DATA_WIDTH-1:0]
);
   logic s_valid;
   logic s_ready;
   TYPE  s_data;
   logic tx_valid;
   TYPE  tx_data;
   logic credit_return;

   modport master (
      input  s_valid,
      input  s_data,
      input  credit_return,
      output s_ready,
      output tx_valid,
      output tx_data
   );

   modport slave (
      output s_valid,
      output s_data,
      output credit_return,
      input  s_ready,
      input  tx_valid,
      input  tx_data
   );
endinterface

// File: rtl/credit_tx.sv
// Transmit end of a credit-based link into a remote FIFO.
// s_ready comes from the credit counter, never from the link.
module credit_tx #(
   parameter int  DATA_WIDTH = 1,
   parameter type TYPE       = logic [DATA_WIDTH-1:0],
   parameter int  CREDITS    = 4,
   parameter int  CNT_WIDTH  = $clog2(CREDITS+1)
) (
   input  logic                 clk,
   input  logic                 rstn,
   credit_tx_if.master          bus,
   output logic [CNT_WIDTH-1:0] credit_count,
   output logic                 idle,
   output logic                 overflow_err,
   input  logic                 clr_err
);

   if (CREDITS < 1) begin : g_bad_credits
      $fatal(1, "credit_tx: CREDITS must be >= 1");
   end

   localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(CREDITS);
   localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

   logic                 fire;
   logic                 ret;
   logic                 at_full;
   logic                 ovf_set;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic                 tx_valid_q;
   TYPE                  tx_data_q;

   assign ret     = bus.credit_return;
   assign at_full = (credit_count == FULL);
   assign fire    = bus.s_valid && bus.s_ready;
   assign ovf_set = ret && !fire && at_full;

   assign bus.s_ready  = (credit_count != '0);
   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = tx_data_q;
   assign idle         = at_full && !tx_valid_q;

   // A return with nowhere to go saturates; ovf_set flags it.
   always_comb begin
      cnt_nxt = credit_count;
      unique case (1'b1)
         fire && !ret:             cnt_nxt = credit_count - ONE;
         !fire && ret && !at_full: cnt_nxt = credit_count + ONE;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         credit_count <= FULL;
         tx_valid_q   <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         credit_count <= cnt_nxt;
         tx_valid_q   <= fire;
         if (ovf_set)
            overflow_err <= 1'b1;
         else if (clr_err)
            overflow_err <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (fire)
         tx_data_q <= bus.s_data;
   end

   a_cnt_range: assert property (
      @(posedge clk) disable iff (!rstn)
      credit_count <= FULL);

   a_tx_after_fire: assert property (
      @(posedge clk) disable iff (!rstn)
      tx_valid_q |-> $past(fire));

endmodule

// File: tb/tb_credit_tx.sv
// Directed, table-driven bench for credit_tx with CREDITS=4.
// Each row drives one cycle and checks that cycle's registered outputs.
module tb_credit_tx;

   localparam int DW = 8;
   localparam int CR = 4;
   localparam int CW = $clog2(CR+1);

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          clr_err = 1'b0;
   logic [CW-1:0] credit_count;
   logic          idle;
   logic          overflow_err;

   int ntot = 0;
   int npass = 0;

   credit_tx_if #(.DATA_WIDTH(DW)) bus();

   credit_tx #(
      .DATA_WIDTH(DW),
      .CREDITS(CR)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus),
      .credit_count(credit_count),
      .idle(idle),
      .overflow_err(overflow_err),
      .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   // Upstream protocol: a pending beat stays valid and stable.
   logic          pv = 1'b0;
   logic          pf = 1'b0;
   logic [DW-1:0] pd = '0;
   always @(posedge clk) begin
      if (rstn && pv && !pf)
         assert (bus.s_valid && bus.s_data == pd)
            else $error("upstream beat dropped or changed before fire");
      pv <= bus.s_valid;
      pf <= bus.s_valid && bus.s_ready;
      pd <= bus.s_data;
   end

   typedef struct {
      logic          sv;
      logic [DW-1:0] d;
      logic          cr;
      logic          clr;
      logic [CW-1:0] cnt;
      logic          rdy;
      logic          txv;
      logic [DW-1:0] txd;
      logic          idl;
      logic          err;
   } vec_t;

   vec_t v[$];

   function automatic vec_t mk(
      logic sv, logic [DW-1:0] d, logic cr, logic clr,
      logic [CW-1:0] cnt, logic rdy, logic txv,
      logic [DW-1:0] txd, logic idl, logic err);
      vec_t r;
      r.sv = sv; r.d = d; r.cr = cr; r.clr = clr;
      r.cnt = cnt; r.rdy = rdy; r.txv = txv;
      r.txd = txd; r.idl = idl; r.err = err;
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      ntot++;
      if (act === exp)
         npass++;
      else
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data = '0;
      bus.credit_return = 1'b0;

      //          sv d     cr clr cnt rdy txv txd   idl err
      v.push_back(mk(1, 8'h01, 0, 0, 4, 1, 0, 8'h00, 1, 0));
      v.push_back(mk(1, 8'h02, 0, 0, 3, 1, 1, 8'h01, 0, 0));
      v.push_back(mk(1, 8'h03, 0, 0, 2, 1, 1, 8'h02, 0, 0));
      v.push_back(mk(1, 8'h04, 0, 0, 1, 1, 1, 8'h03, 0, 0));
      v.push_back(mk(1, 8'h05, 0, 0, 0, 0, 1, 8'h04, 0, 0));
      v.push_back(mk(1, 8'h05, 0, 0, 0, 0, 0, 8'h00, 0, 0));
      v.push_back(mk(1, 8'h05, 1, 0, 0, 0, 0, 8'h00, 0, 0));
      v.push_back(mk(1, 8'h05, 0, 0, 1, 1, 0, 8'h00, 0, 0));
      v.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 8'h05, 0, 0));
      v.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
      v.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 0, 0));
      v.push_back(mk(0, 8'h00, 1, 0, 2, 1, 0, 8'h00, 0, 0));
      v.push_back(mk(0, 8'h00, 1, 0, 3, 1, 0, 8'h00, 0, 0));
      v.push_back(mk(0, 8'h00, 0, 0, 4, 1, 0, 8'h00, 1, 0));
      v.push_back(mk(0, 8'h00, 1, 0, 4, 1, 0, 8'h00, 1, 0));
      v.push_back(mk(0, 8'h00, 0, 0, 4, 1, 0, 8'h00, 1, 1));
      v.push_back(mk(0, 8'h00, 0, 1, 4, 1, 0, 8'h00, 1, 1));
      v.push_back(mk(0, 8'h00, 0, 0, 4, 1, 0, 8'h00, 1, 0));
      v.push_back(mk(0, 8'h00, 1, 1, 4, 1, 0, 8'h00, 1, 0));
      v.push_back(mk(0, 8'h00, 0, 0, 4, 1, 0, 8'h00, 1, 1));
      v.push_back(mk(0, 8'h00, 0, 1, 4, 1, 0, 8'h00, 1, 1));
      v.push_back(mk(0, 8'h00, 0, 0, 4, 1, 0, 8'h00, 1, 0));
      v.push_back(mk(1, 8'h10, 1, 0, 4, 1, 0, 8'h00, 1, 0));
      v.push_back(mk(1, 8'h11, 0, 0, 4, 1, 1, 8'h10, 0, 0));
      v.push_back(mk(1, 8'h12, 0, 0, 3, 1, 1, 8'h11, 0, 0));
      v.push_back(mk(1, 8'h13, 0, 0, 2, 1, 1, 8'h12, 0, 0));
      v.push_back(mk(1, 8'h14, 1, 0, 1, 1, 1, 8'h13, 0, 0));
      v.push_back(mk(1, 8'h15, 1, 0, 1, 1, 1, 8'h14, 0, 0));
      v.push_back(mk(1, 8'h16, 1, 0, 1, 1, 1, 8'h15, 0, 0));
      v.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 8'h16, 0, 0));
      v.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 0, 0));
      v.push_back(mk(0, 8'h00, 1, 0, 2, 1, 0, 8'h00, 0, 0));
      v.push_back(mk(0, 8'h00, 1, 0, 3, 1, 0, 8'h00, 0, 0));
      v.push_back(mk(0, 8'h00, 0, 0, 4, 1, 0, 8'h00, 1, 0));

      repeat (2) @(posedge clk);
      #1;
      chk("rst cnt", 32'(credit_count), 4);
      chk("rst rdy", 32'(bus.s_ready), 1);
      chk("rst txv", 32'(bus.tx_valid), 0);
      chk("rst idle", 32'(idle), 1);
      chk("rst err", 32'(overflow_err), 0);
      rstn = 1'b1;
      step();

      foreach (v[i]) begin
         bus.s_valid = v[i].sv;
         bus.s_data = v[i].d;
         bus.credit_return = v[i].cr;
         clr_err = v[i].clr;
         chk($sformatf("v%0d cnt", i), 32'(credit_count), 32'(v[i].cnt));
         chk($sformatf("v%0d rdy", i), 32'(bus.s_ready), 32'(v[i].rdy));
         chk($sformatf("v%0d txv", i), 32'(bus.tx_valid), 32'(v[i].txv));
         if (v[i].txv)
            chk($sformatf("v%0d txd", i), 32'(bus.tx_data), 32'(v[i].txd));
         chk($sformatf("v%0d idle", i), 32'(idle), 32'(v[i].idl));
         chk($sformatf("v%0d err", i), 32'(overflow_err), 32'(v[i].err));
         step();
      end

      bus.s_valid = 1'b0;
      bus.credit_return = 1'b0;
      clr_err = 1'b0;

      // Three beats out, then reset while one is still on the link.
      for (int k = 0; k < 3; k++) begin
         bus.s_valid = 1'b1;
         bus.s_data = 8'h20 + 8'(k);
         step();
      end
      bus.s_valid = 1'b0;
      chk("pre-rst cnt", 32'(credit_count), 1);
      chk("pre-rst txv", 32'(bus.tx_valid), 1);
      chk("pre-rst txd", 32'(bus.tx_data), 32'h22);
      rstn = 1'b0;
      #1;
      chk("mid-rst cnt", 32'(credit_count), 4);
      chk("mid-rst txv", 32'(bus.tx_valid), 0);
      chk("mid-rst idle", 32'(idle), 1);
      chk("mid-rst rdy", 32'(bus.s_ready), 1);
      step();
      rstn = 1'b1;
      chk("post-rst cnt", 32'(credit_count), 4);
      bus.s_valid = 1'b1;
      bus.s_data = 8'h30;
      step();
      bus.s_valid = 1'b0;
      chk("resume txv", 32'(bus.tx_valid), 1);
      chk("resume txd", 32'(bus.tx_data), 32'h30);
      chk("resume cnt", 32'(credit_count), 3);
      step();
      chk("resume txv0", 32'(bus.tx_valid), 0);
      chk("resume cnt2", 32'(credit_count), 3);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/credit_tx.md
Name: credit_tx

Overview:
- Transmit end of a credit-based link that feeds a remote `fifo` instance.
- Accepts a local valid/ready stream and forwards each beat over a registered, ready-less link (`tx_valid`/`tx_data`).
- Tracks free slots in the remote FIFO with a credit counter. The remote side returns one credit per beat it pops.
- Lets long or pipelined wires replace a combinational `w_ready` path back to the FIFO writer.

Parameters:
- DATA_WIDTH, 1, payload width when TYPE is not overridden.
- TYPE, logic [DATA_WIDTH-1:0], payload type carried on the link.
- CREDITS, 4, initial credit count; must equal the DEPTH of the remote FIFO. Must be >= 1; static `$fatal` otherwise.
- CNT_WIDTH, $clog2(CREDITS+1), derived width of the credit counter. Do not override.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset.
- s_valid  input  1  upstream beat valid.
- s_ready  output  1  upstream beat accepted when high together with s_valid.
- s_data  input  $bits(TYPE)  upstream payload.
- tx_valid  output  1  link beat strobe, one cycle per beat, registered.
- tx_data  output  $bits(TYPE)  link payload, registered.
- credit_return  input  1  one-cycle pulse from the remote side; each high cycle returns one credit.
- credit_count  output  CNT_WIDTH  current available credits, registered.
- idle  output  1  high when credit_count == CREDITS and tx_valid == 0; all sent beats consumed remotely.
- overflow_err  output  1  sticky error: a credit was returned with the counter already at CREDITS.
- clr_err  input  1  synchronous clear of overflow_err.

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk.
- Reset values:
  - credit_count = CREDITS.
  - tx_valid = 0.
  - overflow_err = 0.
  - idle = 1.
  - tx_data is not reset and is don't-care while tx_valid = 0.
- s_ready = (credit_count != 0).
  - Depends only on registered state; no combinational path from s_valid, s_data or credit_return.
- Handshake: fire = s_valid && s_ready.
  - s_data must be held by upstream until fire; s_valid must not drop without fire (checked by assertion in the bench).
- Latency: one cycle. Fire in cycle N gives tx_valid = 1 and tx_data = s_data@N in cycle N+1.
  - No fire in N gives tx_valid = 0 in N+1; tx_data keeps its last value.
- Back-to-back: a continuous stream with available credits produces one tx beat per cycle with no bubbles.
- Credit counter next value:
  - fire only: count - 1.
  - credit_return only: count + 1.
  - both in the same cycle: unchanged.
  - neither: unchanged.
- Zero credits:
  - s_ready = 0, so fire is impossible and count cannot underflow.
  - A credit_return in a zero-credit cycle makes s_ready = 1 in the following cycle. No same-cycle bypass.
- Overflow: credit_return with count == CREDITS and no fire.
  - count saturates at CREDITS.
  - overflow_err = 1 from the next cycle.
  - The error stays set until clr_err or reset.
  - If clr_err and a new overflow occur in the same cycle, the set wins.
- Full credits with both fire and credit_return: legal. Count stays CREDITS; no error.
- CREDITS = 1: the same rules apply.
  - The counter toggles between 1 and 0.
  - At most one beat is in flight.
- Reset mid-stream:
  - Any pending tx beat is dropped and credits are restored to CREDITS.
  - The remote FIFO must be reset in the same domain and at the same time. This is a system requirement, documented, and not checked by this block.
- Width rules:
  - CNT_WIDTH holds 0..CREDITS inclusive.
  - Increment and decrement are done at CNT_WIDTH bits; the saturation compare is against CREDITS.
- Assertions, simulation only:
  - credit_count <= CREDITS always.
  - tx_valid implies a fire in the previous cycle.

Test Plan:
- Reset with CREDITS=4 -> credit_count=4, s_ready=1, tx_valid=0, idle=1, overflow_err=0.
- s_valid held with data 0x1,0x2,0x3,0x4,0x5 and no returns -> four fires, tx beats 0x1..0x4 on consecutive cycles one cycle after each fire. credit_count 4->0; s_ready=0 with 0x5 stalled, held and not sent.
- From zero credits, a single credit_return pulse -> credit_count=1, s_ready=1 next cycle. 0x5 fires and appears on tx one cycle later; credit_count back to 0.
- Continuous stream with credit_return every cycle after the first four beats -> credit_count constant, one tx beat per cycle, no bubbles, data in order.
- At credit_count=4, idle, pulse credit_return -> overflow_err=1 next cycle, credit_count stays 4. clr_err pulse -> overflow_err=0 next cycle.
- Deassert rstn mid-stream with credit_count=1 and tx_valid=1 -> asynchronously credit_count=4, tx_valid=0, idle=1. After release, the stream resumes from fresh credits.
